// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-writable dual-port RAM and its clear sequencer.
package ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  function automatic int nbytes_of(input int dwidth);
    return dwidth / BYTE_W;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, holding busy high until done.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter  int AWIDTH = 3,
  localparam int DEPTH  = 2**AWIDTH
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              busy,
  output logic [AWIDTH-1:0] clr_addr
);

  localparam logic [AWIDTH:0] LAST = (AWIDTH+1)'(DEPTH - 1);

  clr_state_t      state;
  // One extra bit lets the count settle at DEPTH instead of wrapping to 0.
  logic [AWIDTH:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      count <= '0;
      busy  <= 1'b1;
    end else if (state == CLEAR) begin
      count <= count + 1'b1;
      if (count == LAST) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

  assign clr_addr = count[AWIDTH-1:0];

endmodule

// File: rtl/ram_sync_dp_bw.sv
// Simple dual-port synchronous RAM with byte enables, write-first bypass and optional output register.
// Optional hardware clear at reset is built when RAM_SYNC_DP_BW_INIT_CLEAR_EN is defined.
module ram_sync_dp_bw
  import ram_pkg::*;
#(
  parameter  int AWIDTH  = 3,
  parameter  int DWIDTH  = 32,
  parameter  int OUT_REG = 0,
  localparam int DEPTH   = 2**AWIDTH,
  localparam int NBYTES  = nbytes_of(DWIDTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [NBYTES-1:0] wr_be,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  if (DWIDTH % BYTE_W != 0) begin : g_bad_width
    $fatal(1, "ram_sync_dp_bw: DWIDTH must be a multiple of 8");
  end

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_data;
  logic [NBYTES-1:0] mem_be;

`ifdef RAM_SYNC_DP_BW_INIT_CLEAR_EN
  logic [AWIDTH-1:0] clr_addr;

  ram_clear_seq #(.AWIDTH(AWIDTH)) u_clear_seq (
    .clock    (clock),
    .reset_n  (reset_n),
    .busy     (busy),
    .clr_addr (clr_addr)
  );

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mem_we   = wr_en;
    mem_addr = wr_addr;
    mem_data = wr_data;
    mem_be   = wr_be;
    if (busy) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr;
      mem_data = '0;
      mem_be   = '1;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    mem_we   = wr_en;
    mem_addr = wr_addr;
    mem_data = wr_data;
    mem_be   = wr_be;
  end
`endif

  logic wr_acc;
  logic rd_acc;

  assign wr_acc = wr_en & ~busy;
  assign rd_acc = rd_en & ~busy;

  // NOTE: the array has no reset so it maps onto RAM macros; contents come from writes or the clear sequencer.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_be[b]) mem[mem_addr][b*BYTE_W +: BYTE_W] <= mem_data[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Write-first: lanes being written this cycle at the read address take the incoming data.
  logic [DWIDTH-1:0] rd_word;

  always_comb begin
    rd_word = mem[rd_addr];
    for (int b = 0; b < NBYTES; b++) begin
      if (wr_acc && (wr_addr == rd_addr) && wr_be[b]) rd_word[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
    end
  end

  logic              s1_valid;
  logic [DWIDTH-1:0] s1_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= s1_valid;
        if (s1_valid) rd_data <= s1_data;
      end
    end
  end else begin : g_no_out_reg
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
  end

endmodule

// File: tb/tb_ram_sync_dp_bw.sv
// Bench for ram_sync_dp_bw: two instances (OUT_REG=0 and 1) on shared stimulus, checked against a word-array model.
module tb_ram_sync_dp_bw;

`ifdef RAM_SYNC_DP_BW_INIT_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, busy0, busy1;

  ram_sync_dp_bw #(.AWIDTH(3), .DWIDTH(32), .OUT_REG(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0)
  );

  ram_sync_dp_bw #(.AWIDTH(3), .DWIDTH(32), .OUT_REG(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: memory contents, edges since reset release, and what each output should show.
  logic [31:0] mdl [DEPTH];
  int          edges;
  logic        e0_v, p_v, e1_v;
  logic [31:0] e0_d, p_d, e1_d;

  function automatic bit mdl_busy();
    return CLEAR_EN && (edges < DEPTH);
  endfunction

  task automatic cycle(input bit we, input logic [2:0] wa, input logic [31:0] wd, input logic [3:0] wbe,
                       input bit re, input logic [2:0] ra);
    logic [31:0] val;
    bit          blocked;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe; rd_en = re; rd_addr = ra;
    blocked = mdl_busy();
    val = mdl[ra];
    for (int b = 0; b < 4; b++)
      if (we && wa == ra && wbe[b]) val[8*b +: 8] = wd[8*b +: 8];
    e1_v = p_v;
    if (p_v) e1_d = p_d;
    p_v = re && !blocked;
    if (p_v) p_d = val;
    e0_v = p_v;
    if (p_v) e0_d = val;
    if (we && !blocked)
      for (int b = 0; b < 4; b++)
        if (wbe[b]) mdl[wa][8*b +: 8] = wd[8*b +: 8];
    if (edges < 100000) edges++;
    @(posedge clock);
    #1;
    check("busy0", 32'(busy0), 32'(mdl_busy()));
    check("busy1", 32'(busy1), 32'(mdl_busy()));
    check("rd_valid0", 32'(rd_valid0), 32'(e0_v));
    check("rd_data0", rd_data0, e0_d);
    check("rd_valid1", 32'(rd_valid1), 32'(e1_v));
    check("rd_data1", rd_data1, e1_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 3'd0);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous reset values, releases on the falling edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    #1;
    check("rst_valid0", 32'(rd_valid0), 32'd0);
    check("rst_valid1", 32'(rd_valid1), 32'd0);
    check("rst_data0", rd_data0, 32'd0);
    check("rst_data1", rd_data1, 32'd0);
    check("rst_busy", 32'(busy0), 32'(CLEAR_EN));
    e0_v = 1'b0; p_v = 1'b0; e1_v = 1'b0;
    e0_d = '0; p_d = '0; e1_d = '0;
    edges = 0;
    if (CLEAR_EN) for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  int vcount;

  initial begin
    for (int a = 0; a < DEPTH; a++) mdl[a] = 'x;
    e0_v = 1'b0; p_v = 1'b0; e1_v = 1'b0;
    e0_d = '0; p_d = '0; e1_d = '0;
    edges = 0;
    @(negedge clock);
    do_reset();

    // Clear phase (busy for DEPTH cycles) or, without the sequencer, explicit initialisation.
    if (CLEAR_EN) begin
      idle(DEPTH);
      for (int a = 0; a < DEPTH; a++) begin
        cycle(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'(a));
        check("clr_zero", rd_data0, 32'h0000_0000);
      end
    end else begin
      for (int a = 0; a < DEPTH; a++) cycle(1'b1, 3'(a), 32'h0101_0101 * a, 4'hF, 1'b0, 3'd0);
    end

    // Full then partial write to address 5.
    cycle(1'b1, 3'd5, 32'hDEAD_BEEF, 4'hF, 1'b0, 3'd0);
    cycle(1'b1, 3'd5, 32'h1122_3344, 4'b0101, 1'b0, 3'd0);
    cycle(1'b1, 3'd5, 32'hFFFF_FFFF, 4'b0000, 1'b1, 3'd5);
    check("partial_wr", rd_data0, 32'hDE22_BE44);

    // Same-cycle write/read: enabled lanes bypass, the rest return old contents.
    cycle(1'b1, 3'd2, 32'h1234_5678, 4'hF, 1'b0, 3'd0);
    cycle(1'b1, 3'd2, 32'hAAAA_AAAA, 4'b0011, 1'b1, 3'd2);
    check("bypass", rd_data0, 32'h1234_AAAA);
    idle(2);

    // Back-to-back reads 0..7: the registered-output instance shows 8 valid cycles, 2 after the first request.
    vcount = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 3'd0, 32'd0, 4'd0, k < DEPTH, 3'(k));
      check("stream_v1", 32'(rd_valid1), 32'(k >= 1 && k <= DEPTH));
      if (rd_valid1) vcount++;
    end
    check("stream_cnt", 32'(vcount), 32'(DEPTH));

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), 3'($urandom), $urandom, 4'($urandom), 1'($urandom), 3'($urandom));

    // Reset with a read in flight: valid drops immediately.
    cycle(1'b1, 3'd6, 32'hA5A5_0F0F, 4'hF, 1'b1, 3'd6);
    do_reset();
    if (CLEAR_EN) begin
      // A write during the clear is dropped.
      cycle(1'b1, 3'd3, 32'hCAFE_F00D, 4'hF, 1'b0, 3'd0);
      idle(DEPTH - 1);
      cycle(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'd3);
      check("busy_wr_drop", rd_data0, 32'h0000_0000);

      // Reset pulsed at clear cycle 4 restarts a full clear; reads issued meanwhile are dropped.
      do_reset();
      idle(4);
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
        cycle(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'(k));
        check("reclr_valid", 32'(rd_valid0), 32'd0);
      end
      check("reclr_done", 32'(busy0), 32'd0);
    end
    cycle(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'd6);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
